seg_data_memory: RTL and testbench
==================================

# seg_data_memory

Parametrised word-addressed data memory for the multi-cycle RISC datapath, replacing the fixed 32-bit single-array memory. Partitions storage into a data segment and a stack segment, supports byte-enabled writes, a configurable read latency with a req/ready/done handshake, and bounds and segment checking with a fault report. Sits between the memory-stage control FSM and the register write-back mux.

## Interface
- DATA_W, 32, data word width in bits; multiple of 8.
- ADDR_W, 32, address width in bits; word address.
- DEPTH, 512, total words of storage.
- STACK_BASE, 256, first word of the stack segment; data segment is 0..STACK_BASE-1, stack is STACK_BASE..DEPTH-1.
- READ_LAT, 1, extra wait cycles per read, 0..7.

- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request strobe; accepted on a rising edge where req=1 and ready=1.
- we  in  1  1 = write, 0 = read; sampled with req.
- seg  in  1  0 = data-segment access, 1 = stack access; sampled with req.
- addr  in  ADDR_W  word address; sampled with req.
- wdata  in  DATA_W  write data; sampled with req.
- be  in  DATA_W/8  byte enables for writes; bit i writes byte i; ignored on reads.
- ready  out  1  block can accept a request this cycle.
- done  out  1  one-cycle completion pulse for every accepted request.
- rdata  out  DATA_W  read data; valid only while done=1 for a read; 0 otherwise.
- fault  out  1  valid with done; 1 = request rejected.
- fault_code  out  2  valid with done: 00 ok, 01 segment mismatch, 10 out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: ready=1. Accepted write -> commit masked bytes at the accepting edge, go to RESP. Accepted read -> latch the address, go to WAIT if READ_LAT>0, else RESP.
- WAIT: ready=0. Counter loads READ_LAT-1 at acceptance and decrements each cycle. At 0 the word is read and the state goes to RESP.
- RESP: done=1 for exactly one cycle. For reads, rdata = stored word. Then return to IDLE.
- Exception for writes: writes complete in RESP, but ready stays 1 in RESP after a write. A new request accepted in that cycle is processed normally, so back-to-back writes run at one per cycle.
- Checks are applied at acceptance, in this priority:
  - addr ≥ DEPTH (full ADDR_W compare): code 10.
  - seg=0 with addr ≥ STACK_BASE, or seg=1 with addr < STACK_BASE: code 01.
- A faulting request never modifies memory. It skips WAIT and goes to RESP with done=1, fault=1, rdata=0.
- Read-after-write to the same address returns the new data, including a read accepted in the RESP cycle of that write.
- Reads with be=0 are normal reads. Writes with be=0 complete with done=1 and change nothing.
- Memory contents are not cleared by reset and are uninitialised at power-up. The testbench preloads them hierarchically.

## Timing
- While reset=1: state IDLE, ready=0, done=0, rdata=0, fault=0, fault_code=00. ready=1 from the first cycle after reset is sampled low.
- Reset asserted during WAIT or RESP aborts the operation. No done pulse follows. A write already committed at its accepting edge stays committed.
- Write accepted at edge N: done=1 during cycle N..N+1.
- Read accepted at edge N: done and rdata are valid during the cycle after edge N+1+READ_LAT. ready=0 from edge N until done falls.
- req is ignored while ready=0; there is no queueing.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan
- Reset, then write 0xDEADBEEF, be=1111, seg=0, addr=5 → done 1 cycle later, fault=0. Read addr 5 (READ_LAT=1) → done 2 cycles after acceptance with rdata=0xDEADBEEF; ready low between acceptance and done.
- Byte enables: preload addr 7 = 0x11223344; write 0xAABBCCDD with be=0101 → read returns 0x11BB33DD.
- Segment faults:
  - seg=0 write to addr 300 → done, fault=1, code 01; addr 300 unchanged.
  - seg=1 read of addr 300 → rdata as stored, fault=0.
  - addr 600 → code 10, rdata=0.
- Back-to-back writes to addrs 256..259 on consecutive cycles with seg=1 → four done pulses in four cycles. Then read addr 259, accepted in the last RESP cycle → new value.
- Reset mid-read: READ_LAT=3; assert reset in the cycle after acceptance → no done pulse; all outputs 0; ready=1 one cycle after reset deasserts.
- Sweep READ_LAT=0 and 7 → done latency of 1 and 8 cycles respectively.

Source files
------------

// File: rtl/seg_data_memory.sv
// Word-addressed data memory with a data segment and a stack segment.
// Byte-enabled writes complete in one cycle; reads wait READ_LAT extra
// cycles. Each request is bounds- and segment-checked when accepted.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a request (ready asserted from the next cycle)
// WAIT   | read latency countdown
// RESP   | read: load rdata/done next edge; write: done showing, ready
module seg_data_memory #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 512,
    parameter int STACK_BASE = 256,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic                  seg_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   be_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  fault_o,
    output logic [1:0]            fault_code_o
);

    localparam int MW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [MW-1:0]     raddr_q, raddr_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;
    logic [1:0]        code_q, code_d;

    logic              accept;
    logic              out_of_range;
    logic              seg_bad;
    logic [1:0]        chk_code;
    logic              mem_we;
    logic [MW-1:0]     mem_idx;

    // Request checks: range violation outranks segment mismatch.
    always_comb begin
        accept       = req_i && ready_q;
        out_of_range = addr_i >= ADDR_W'(DEPTH);
        seg_bad      = seg_i ? (addr_i < ADDR_W'(STACK_BASE))
                             : (addr_i >= ADDR_W'(STACK_BASE));
        chk_code     = out_of_range ? 2'b10 : (seg_bad ? 2'b01 : 2'b00);
        mem_we       = accept && we_i && (chk_code == 2'b00) && !reset_i;
        mem_idx      = addr_i[MW-1:0];
    end

    // Masked byte writes commit at the accepting edge; storage has no reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (be_i[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    // Next-state and registered-output logic. RESP tells a read apart from
    // a write by ready_q, which is held low for the whole of a read.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        raddr_d = raddr_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        rdata_d = '0;
        fault_d = 1'b0;
        code_d  = 2'b00;
        if (accept) begin
            if (chk_code != 2'b00) begin
                done_d  = 1'b1;
                fault_d = 1'b1;
                code_d  = chk_code;
                ready_d = we_i;
                state_d = we_i ? S_RESP : S_IDLE;
            end else if (we_i) begin
                done_d  = 1'b1;
                ready_d = 1'b1;
                state_d = S_RESP;
            end else begin
                raddr_d = mem_idx;
                ready_d = 1'b0;
                if (READ_LAT > 0) begin
                    state_d = S_WAIT;
                    cnt_d   = 3'(READ_LAT - 1);
                end else begin
                    state_d = S_RESP;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: ready_d = 1'b1;
                S_WAIT: begin
                    if (cnt_q == 3'd0) state_d = S_RESP;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                S_RESP: begin
                    state_d = S_IDLE;
                    if (!ready_q) begin
                        done_d  = 1'b1;
                        rdata_d = mem_q[raddr_q];
                    end else begin
                        ready_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers, synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            raddr_q <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            raddr_q <= raddr_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            code_q  <= code_d;
        end
    end

    assign ready_o      = ready_q;
    assign done_o       = done_q;
    assign rdata_o      = rdata_q;
    assign fault_o      = fault_q;
    assign fault_code_o = code_q;

endmodule

// File: tb/tb_seg_data_memory.sv
// Directed bench for seg_data_memory with four latency variants.
// Index map: 0 = READ_LAT 1, 1 = READ_LAT 0, 2 = READ_LAT 3, 3 = READ_LAT 7.
module tb_seg_data_memory;

    logic        clk;
    logic        reset;
    logic [3:0]  req_v;
    logic        we;
    logic        seg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  ready_v;
    logic [3:0]  done_v;
    logic [3:0]  fault_v;
    logic [31:0] rdata_a [4];
    logic [1:0]  code_a  [4];

    int errors = 0;
    int checks = 0;

    seg_data_memory #(.READ_LAT(1)) u_l1 (
        .clk_i(clk), .reset_i(reset), .req_i(req_v[0]), .we_i(we), .seg_i(seg),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .ready_o(ready_v[0]),
        .done_o(done_v[0]), .rdata_o(rdata_a[0]), .fault_o(fault_v[0]),
        .fault_code_o(code_a[0]));

    seg_data_memory #(.READ_LAT(0)) u_l0 (
        .clk_i(clk), .reset_i(reset), .req_i(req_v[1]), .we_i(we), .seg_i(seg),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .ready_o(ready_v[1]),
        .done_o(done_v[1]), .rdata_o(rdata_a[1]), .fault_o(fault_v[1]),
        .fault_code_o(code_a[1]));

    seg_data_memory #(.READ_LAT(3)) u_l3 (
        .clk_i(clk), .reset_i(reset), .req_i(req_v[2]), .we_i(we), .seg_i(seg),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .ready_o(ready_v[2]),
        .done_o(done_v[2]), .rdata_o(rdata_a[2]), .fault_o(fault_v[2]),
        .fault_code_o(code_a[2]));

    seg_data_memory #(.READ_LAT(7)) u_l7 (
        .clk_i(clk), .reset_i(reset), .req_i(req_v[3]), .we_i(we), .seg_i(seg),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .ready_o(ready_v[3]),
        .done_o(done_v[3]), .rdata_o(rdata_a[3]), .fault_o(fault_v[3]),
        .fault_code_o(code_a[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called just after a negedge. Presents one request to instance idx and
    // returns k = edges after the accepting edge until done is seen
    // (write -> 0), plus whether ready was seen high while waiting.
    task automatic issue(input int idx, input logic w, input logic s,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, output int k, output logic rdy_seen);
        we = w; seg = s; addr = a; wdata = d; be = b;
        req_v = '0;
        req_v[idx] = 1'b1;
        @(negedge clk);
        req_v = '0;
        k = 0;
        rdy_seen = 1'b0;
        while (done_v[idx] !== 1'b1 && k < 20) begin
            if (ready_v[idx] === 1'b1) rdy_seen = 1'b1;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ready_v[0] !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", ready_v[0]); end
        checks++; if (done_v[0] !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done_v[0]); end
        checks++; if (rdata_a[0] !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", rdata_a[0]); end
        checks++; if (fault_v[0] !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b expected 0", fault_v[0]); end
        checks++; if (code_a[0] !== 2'b00) begin errors++; $display("FAIL rst_code: got %b expected 00", code_a[0]); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ready_v !== 4'hF) begin errors++; $display("FAIL rst_ready_after: got %b expected 1111", ready_v); end
    endtask

    task automatic test_write_read();
        int k; logic rs;
        issue(0, 1'b1, 1'b0, 32'd5, 32'hDEADBEEF, 4'hF, k, rs);
        checks++; if (k !== 0) begin errors++; $display("FAIL wr_latency: got %0d expected 0", k); end
        checks++; if (fault_v[0] !== 1'b0) begin errors++; $display("FAIL wr_fault: got %b expected 0", fault_v[0]); end
        checks++; if (ready_v[0] !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b expected 1", ready_v[0]); end
        @(negedge clk);
        checks++; if (done_v[0] !== 1'b0) begin errors++; $display("FAIL wr_done_pulse: got %b expected 0", done_v[0]); end
        issue(0, 1'b0, 1'b0, 32'd5, 32'h0, 4'hF, k, rs);
        checks++; if (k !== 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", k); end
        checks++; if (rdata_a[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rdata_a[0]); end
        checks++; if (rs !== 1'b0 || ready_v[0] !== 1'b0) begin errors++; $display("FAIL rd_ready_low: got %b/%b expected 0/0", rs, ready_v[0]); end
        @(negedge clk);
        checks++; if (done_v[0] !== 1'b0 || ready_v[0] !== 1'b1 || rdata_a[0] !== 32'h0) begin
            errors++; $display("FAIL rd_after: got done=%b ready=%b rdata=%h expected 0/1/0", done_v[0], ready_v[0], rdata_a[0]);
        end
    endtask

    task automatic test_byte_enable();
        int k; logic rs;
        issue(0, 1'b1, 1'b0, 32'd7, 32'hAABBCCDD, 4'b0101, k, rs);
        @(negedge clk);
        issue(0, 1'b0, 1'b0, 32'd7, 32'h0, 4'h0, k, rs);
        checks++; if (rdata_a[0] !== 32'h11BB33DD) begin errors++; $display("FAIL be_merge: got %h expected 11bb33dd", rdata_a[0]); end
        @(negedge clk);
        issue(0, 1'b1, 1'b0, 32'd7, 32'hFFFFFFFF, 4'h0, k, rs);
        checks++; if (k !== 0 || fault_v[0] !== 1'b0) begin errors++; $display("FAIL be_zero_done: got k=%0d fault=%b expected 0/0", k, fault_v[0]); end
        @(negedge clk);
        issue(0, 1'b0, 1'b0, 32'd7, 32'h0, 4'h0, k, rs);
        checks++; if (rdata_a[0] !== 32'h11BB33DD) begin errors++; $display("FAIL be_zero_nochange: got %h expected 11bb33dd", rdata_a[0]); end
        @(negedge clk);
    endtask

    task automatic test_segment_faults();
        int k; logic rs;
        issue(0, 1'b1, 1'b0, 32'd300, 32'hFFFFFFFF, 4'hF, k, rs);
        checks++; if (k !== 0 || fault_v[0] !== 1'b1 || code_a[0] !== 2'b01) begin
            errors++; $display("FAIL seg0_wr300: got k=%0d fault=%b code=%b expected 0/1/01", k, fault_v[0], code_a[0]);
        end
        repeat (2) @(negedge clk);
        issue(0, 1'b0, 1'b1, 32'd300, 32'h0, 4'hF, k, rs);
        checks++; if (k !== 2 || fault_v[0] !== 1'b0 || rdata_a[0] !== 32'h0BADF00D) begin
            errors++; $display("FAIL seg1_rd300: got k=%0d fault=%b rdata=%h expected 2/0/0badf00d", k, fault_v[0], rdata_a[0]);
        end
        @(negedge clk);
        issue(0, 1'b0, 1'b0, 32'd600, 32'h0, 4'hF, k, rs);
        checks++; if (k !== 0 || fault_v[0] !== 1'b1 || code_a[0] !== 2'b10 || rdata_a[0] !== 32'h0) begin
            errors++; $display("FAIL range600: got k=%0d fault=%b code=%b rdata=%h expected 0/1/10/0", k, fault_v[0], code_a[0], rdata_a[0]);
        end
        @(negedge clk);
        checks++; if (ready_v[0] !== 1'b1) begin errors++; $display("FAIL fault_rd_ready: got %b expected 1", ready_v[0]); end
        issue(0, 1'b1, 1'b1, 32'd100, 32'h12345678, 4'hF, k, rs);
        checks++; if (fault_v[0] !== 1'b1 || code_a[0] !== 2'b01) begin
            errors++; $display("FAIL seg1_wr100: got fault=%b code=%b expected 1/01", fault_v[0], code_a[0]);
        end
        repeat (2) @(negedge clk);
        issue(0, 1'b1, 1'b1, 32'd600, 32'h12345678, 4'hF, k, rs);
        checks++; if (code_a[0] !== 2'b10) begin errors++; $display("FAIL prio_range: got %b expected 10", code_a[0]); end
        repeat (2) @(negedge clk);
        issue(0, 1'b0, 1'b0, 32'h80000005, 32'h0, 4'hF, k, rs);
        checks++; if (fault_v[0] !== 1'b1 || code_a[0] !== 2'b10) begin
            errors++; $display("FAIL range_high: got fault=%b code=%b expected 1/10", fault_v[0], code_a[0]);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int k; logic rs;
        int pulses;
        pulses = 0;
        we = 1'b1; seg = 1'b1; be = 4'hF;
        for (int i = 0; i < 4; i++) begin
            addr = 32'd256 + 32'(i);
            wdata = 32'hC0DE0000 + 32'(i);
            req_v = 4'b0001;
            @(negedge clk);
            if (done_v[0] === 1'b1 && ready_v[0] === 1'b1 && fault_v[0] === 1'b0) pulses++;
        end
        checks++; if (pulses !== 4) begin errors++; $display("FAIL b2b_pulses: got %0d expected 4", pulses); end
        issue(0, 1'b0, 1'b1, 32'd259, 32'h0, 4'hF, k, rs);
        checks++; if (k !== 2 || rdata_a[0] !== 32'hC0DE0003) begin
            errors++; $display("FAIL b2b_raw: got k=%0d rdata=%h expected 2/c0de0003", k, rdata_a[0]);
        end
        @(negedge clk);
        issue(0, 1'b0, 1'b1, 32'd256, 32'h0, 4'hF, k, rs);
        checks++; if (rdata_a[0] !== 32'hC0DE0000) begin errors++; $display("FAIL b2b_first: got %h expected c0de0000", rdata_a[0]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int dn;
        logic nz;
        dn = 0;
        nz = 1'b0;
        we = 1'b0; seg = 1'b0; addr = 32'd5; be = 4'hF;
        req_v = 4'b0100;
        @(negedge clk);
        req_v = '0;
        checks++; if (ready_v[2] !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b expected 0", ready_v[2]); end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done_v[2] === 1'b1) dn++;
            if (ready_v[2] !== 1'b0 || rdata_a[2] !== 32'h0 || fault_v[2] !== 1'b0 || code_a[2] !== 2'b00) nz = 1'b1;
        end
        checks++; if (nz !== 1'b0) begin errors++; $display("FAIL mid_outputs: got nonzero outputs during reset expected all 0"); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (ready_v[2] !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b expected 1", ready_v[2]); end
        repeat (8) begin
            if (done_v[2] === 1'b1) dn++;
            @(negedge clk);
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL mid_no_done: got %0d done pulses expected 0", dn); end
    endtask

    task automatic test_latency_sweep();
        int k; logic rs;
        issue(1, 1'b0, 1'b0, 32'd10, 32'h0, 4'hF, k, rs);
        checks++; if (k !== 1 || rdata_a[1] !== 32'h0000A5A5) begin
            errors++; $display("FAIL lat0_read: got k=%0d rdata=%h expected 1/0000a5a5", k, rdata_a[1]);
        end
        @(negedge clk);
        issue(1, 1'b1, 1'b0, 32'd11, 32'h5A5A5A5A, 4'hF, k, rs);
        issue(1, 1'b0, 1'b0, 32'd11, 32'h0, 4'hF, k, rs);
        checks++; if (k !== 1 || rdata_a[1] !== 32'h5A5A5A5A) begin
            errors++; $display("FAIL lat0_raw: got k=%0d rdata=%h expected 1/5a5a5a5a", k, rdata_a[1]);
        end
        @(negedge clk);
        issue(3, 1'b0, 1'b0, 32'd20, 32'h0, 4'hF, k, rs);
        checks++; if (k !== 8 || rdata_a[3] !== 32'h77770007) begin
            errors++; $display("FAIL lat7_read: got k=%0d rdata=%h expected 8/77770007", k, rdata_a[3]);
        end
        checks++; if (rs !== 1'b0) begin errors++; $display("FAIL lat7_ready_low: got %b expected 0", rs); end
        @(negedge clk);
        issue(2, 1'b0, 1'b1, 32'd300, 32'h0, 4'hF, k, rs);
        checks++; if (k !== 4 || rdata_a[2] !== 32'h33330003) begin
            errors++; $display("FAIL lat3_read: got k=%0d rdata=%h expected 4/33330003", k, rdata_a[2]);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        req_v = '0;
        we = 1'b0; seg = 1'b0; addr = '0; wdata = '0; be = '0;
        u_l1.mem_q[7]   = 32'h11223344;
        u_l1.mem_q[300] = 32'h0BADF00D;
        u_l0.mem_q[10]  = 32'h0000A5A5;
        u_l7.mem_q[20]  = 32'h77770007;
        u_l3.mem_q[300] = 32'h33330003;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_enable();
        test_segment_faults();
        test_back_to_back();
        test_reset_mid_read();
        test_latency_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
